// File: rtl/dac_code_sequencer_pkg.sv
// dac_seq_pkg: types and constants shared by the DAC code sequencer.
//   state_t : sequencer FSM states
//   mode_t  : waveform selection (matches the cfg_mode encoding)
// Optional feature macro used elsewhere in this block: DAC_SEQ_BURST_EN.
package dac_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_UP     = 2'd1,
    MODE_DOWN   = 2'd2,
    MODE_TRI    = 2'd3
  } mode_t;

  localparam int          CODE_W_DEF     = 3;
  localparam logic [2:0]  CODE_MAX       = 3'd7;
  localparam int          SETTLE_CYC_DEF = 8;

endpackage

// File: rtl/dac_code_sequencer_if.sv
// dac_code_sequencer_if: control/config inputs and DAC-side outputs of the
// sequencer, bundled for connection to the analog macro wrapper.
//   start, stop         : single-cycle control pulses
//   cfg_mode/div/code   : waveform configuration, sampled on accepted start
//   cfg_periods         : burst length in periods (only with DAC_SEQ_BURST_EN)
//   dac_code, dac_enable: drive to the DAC bit pins and macro enable
//   busy, wrap          : status
// master drives control/config, slave is the sequencer.
interface dac_code_sequencer_if #(
  parameter int CODE_W = 3,
  parameter int DIV_W  = 16
);
  logic              start;
  logic              stop;
  logic [1:0]        cfg_mode;
  logic [DIV_W-1:0]  cfg_div;
  logic [CODE_W-1:0] cfg_code;
`ifdef DAC_SEQ_BURST_EN
  logic [7:0]        cfg_periods;
`endif
  logic [CODE_W-1:0] dac_code;
  logic              dac_enable;
  logic              busy;
  logic              wrap;

`ifdef DAC_SEQ_BURST_EN
  modport master (output start, stop, cfg_mode, cfg_div, cfg_code, cfg_periods,
                  input  dac_code, dac_enable, busy, wrap);
  modport slave  (input  start, stop, cfg_mode, cfg_div, cfg_code, cfg_periods,
                  output dac_code, dac_enable, busy, wrap);
`else
  modport master (output start, stop, cfg_mode, cfg_div, cfg_code,
                  input  dac_code, dac_enable, busy, wrap);
  modport slave  (input  start, stop, cfg_mode, cfg_div, cfg_code,
                  output dac_code, dac_enable, busy, wrap);
`endif

endinterface

// File: rtl/dac_code_sequencer_prescaler.sv
// dac_seq_prescaler: step-rate prescaler as a down-counter.
//   clk, rst_n : clock, async active-low reset
//   load       : hold the counter at div (used as clear outside RUN)
//   div        : reload value; a tick occurs every div+1 cycles
//   tick       : high in the cycle whose closing edge applies a step
module dac_seq_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load || count == '0) begin
      count <= div;
    end else begin
      count <= count - 1'b1;
    end
  end

  assign tick = !load && (count == '0);

endmodule

// File: rtl/dac_code_sequencer.sv
// dac_code_sequencer: waveform engine producing the 3-bit DAC code and macro
// enable (static level, up-ramp, down-ramp, triangle) at a programmable step
// rate. All outputs are registered.
//   clk, rst_n : project clock, async active-low reset
//   ena        : design enable; low acts as a stop every cycle
//   bus        : dac_code_sequencer_if.slave (control, config, DAC outputs)
// Optional: DAC_SEQ_BURST_EN adds cfg_periods; RUN ends after that many wraps.
//
// state  | meaning
// IDLE   | enable low, code frozen, waiting for start
// SETTLE | enable high at start code for SETTLE_CYC cycles
// RUN    | stepping the code once per prescaler tick
module dac_code_sequencer
  import dac_seq_pkg::*;
#(
  parameter int CODE_W     = CODE_W_DEF,
  parameter int DIV_W      = 16,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input logic                  clk,
  input logic                  rst_n,
  input logic                  ena,
  dac_code_sequencer_if.slave  bus
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CODE_W-1:0] CODE_TOP = {CODE_W{1'b1}};

  state_t            state;
  mode_t             mode_q;
  logic [DIV_W-1:0]  div_q;
  logic [CODE_W-1:0] code_q;
  logic              dir_up;
  logic              en_q;
  logic              busy_q;
  logic              wrap_q;
  logic [SET_W-1:0]  settle_cnt;
  logic              tick;
  logic              halt;
  logic              burst_done;

  logic [CODE_W-1:0] step_code;
  logic              step_up;
  logic              step_wrap;

  assign halt = bus.stop || !ena;

  dac_seq_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state != RUN),
    .div   (div_q),
    .tick  (tick)
  );

`ifdef DAC_SEQ_BURST_EN
  logic [7:0] periods_q;
  logic [7:0] wrap_cnt;
  // wrap_cnt already includes the wrap currently on the output
  assign burst_done = (periods_q != 8'd0) && wrap_q && (wrap_cnt == periods_q);
`else
  assign burst_done = 1'b0;
`endif

  always_comb begin
    step_code = code_q;
    step_up   = dir_up;
    step_wrap = 1'b0;
    case (mode_q)
      MODE_STATIC: step_code = code_q;
      MODE_UP: begin
        step_code = code_q + 1'b1;
        step_wrap = (code_q == CODE_TOP);
      end
      MODE_DOWN: begin
        step_code = code_q - 1'b1;
        step_wrap = (code_q == '0);
      end
      MODE_TRI: begin
        // direction flips on the step that lands on an endpoint, so no
        // endpoint value is repeated
        if (dir_up) begin
          step_code = code_q + 1'b1;
          step_up   = (code_q != CODE_TOP - 1'b1);
        end else begin
          step_code = code_q - 1'b1;
          step_up   = (code_q == {{(CODE_W-1){1'b0}}, 1'b1});
          step_wrap = step_up;
        end
      end
      default: step_code = code_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mode_q     <= MODE_STATIC;
      div_q      <= '0;
      code_q     <= '0;
      dir_up     <= 1'b1;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      wrap_q     <= 1'b0;
      settle_cnt <= '0;
`ifdef DAC_SEQ_BURST_EN
      periods_q  <= 8'd0;
      wrap_cnt   <= 8'd0;
`endif
    end else begin
      wrap_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !halt) begin
            state      <= SETTLE;
            mode_q     <= mode_t'(bus.cfg_mode);
            div_q      <= bus.cfg_div;
            code_q     <= bus.cfg_code;
            dir_up     <= (bus.cfg_code != CODE_TOP);
            en_q       <= 1'b1;
            busy_q     <= 1'b1;
            settle_cnt <= SET_W'(SETTLE_CYC - 1);
`ifdef DAC_SEQ_BURST_EN
            periods_q  <= bus.cfg_periods;
            wrap_cnt   <= 8'd0;
`endif
          end
        end
        SETTLE: begin
          if (halt) begin
            state  <= IDLE;
            en_q   <= 1'b0;
            busy_q <= 1'b0;
          end else if (settle_cnt == '0) begin
            state <= RUN;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        RUN: begin
          if (halt || burst_done) begin
            state  <= IDLE;
            en_q   <= 1'b0;
            busy_q <= 1'b0;
          end else if (tick) begin
            code_q <= step_code;
            dir_up <= step_up;
            wrap_q <= step_wrap;
`ifdef DAC_SEQ_BURST_EN
            if (step_wrap) wrap_cnt <= wrap_cnt + 8'd1;
`endif
          end
        end
        default: begin
          state  <= IDLE;
          en_q   <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dac_code   = code_q;
  assign bus.dac_enable = en_q;
  assign bus.busy       = busy_q;
  assign bus.wrap       = wrap_q;

endmodule

// File: tb/tb_dac_code_sequencer.sv
// tb_dac_code_sequencer: directed self-checking bench for dac_code_sequencer.
// Build with DAC_SEQ_BURST_EN defined to also exercise the burst feature.
module tb_dac_code_sequencer;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic ena   = 1'b0;

  always #5 clk = ~clk;

  dac_code_sequencer_if #(.CODE_W(3), .DIV_W(16)) bus ();

  dac_code_sequencer #(.CODE_W(3), .DIV_W(16), .SETTLE_CYC(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int exp_q[$];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input int mode, input int div, input int code);
    bus.cfg_mode = 2'(mode);
    bus.cfg_div  = 16'(div);
    bus.cfg_code = 3'(code);
    bus.start    = 1'b1;
    tick_n(1);
    bus.start    = 1'b0;
  endtask

  task automatic do_stop();
    bus.stop = 1'b1;
    tick_n(1);
    bus.stop = 1'b0;
  endtask

  // one edge per entry of exp_q; wrap expected only at index wrap_idx
  task automatic run_seq(input string tag, input int wrap_idx);
    foreach (exp_q[i]) begin
      tick_n(1);
      chk({tag, " code"}, int'(bus.dac_code), exp_q[i]);
      chk({tag, " wrap"}, int'(bus.wrap), int'(i == wrap_idx));
      chk({tag, " en"}, int'(bus.dac_enable), 1);
    end
  endtask

  task automatic chk_idle(input string tag, input int code);
    chk({tag, " code"}, int'(bus.dac_code), code);
    chk({tag, " en"}, int'(bus.dac_enable), 0);
    chk({tag, " busy"}, int'(bus.busy), 0);
    chk({tag, " wrap"}, int'(bus.wrap), 0);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.cfg_mode = 2'd0;
    bus.cfg_div  = 16'd0;
    bus.cfg_code = 3'd0;
`ifdef DAC_SEQ_BURST_EN
    bus.cfg_periods = 8'd0;
`endif
    #2 rst_n = 1'b0;
    #6;
    chk_idle("reset", 0);
    rst_n = 1'b1;
    ena   = 1'b1;
    tick_n(1);

    // up-ramp, cfg changes during run must be ignored
    do_start(1, 1, 6);
    chk("up start en", int'(bus.dac_enable), 1);
    chk("up start busy", int'(bus.busy), 1);
    chk("up start code", int'(bus.dac_code), 6);
    bus.cfg_mode = 2'd2;
    bus.cfg_div  = 16'd0;
    bus.cfg_code = 3'd3;
    exp_q = '{6,6,6,6,6,6,6,6,6,7,7,0,0,1,1,2};
    run_seq("up", 11);
    do_stop();
    chk_idle("up stop", 2);
    tick_n(2);
    chk_idle("up frozen", 2);

    // triangle from 5, one step per cycle
    do_start(3, 0, 5);
    exp_q = '{5,5,5,5,5,5,5,5,6,7,6,5,4,3,2,1,0,1};
    run_seq("tri", 16);
    do_stop();
    chk_idle("tri stop", 1);

    // down-ramp, then start+stop together in RUN
    do_start(2, 0, 2);
    exp_q = '{2,2,2,2,2,2,2,2,1,0};
    run_seq("down", -1);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick_n(1);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    chk_idle("startstop", 0);
    tick_n(2);
    chk_idle("startstop hold", 0);
    do_start(2, 0, 2);
    chk("restart code", int'(bus.dac_code), 2);
    chk("restart busy", int'(bus.busy), 1);
    exp_q = '{2,2,2,2,2,2,2,2,1,0,7};
    run_seq("down2", 10);
    do_stop();
    chk_idle("down2 stop", 7);

    // ena low for one cycle in SETTLE, then start with ena low
    do_start(0, 0, 4);
    tick_n(3);
    chk("settle busy", int'(bus.busy), 1);
    ena = 1'b0;
    tick_n(1);
    ena = 1'b1;
    chk_idle("ena drop", 4);
    bus.cfg_code = 3'd1;
    ena = 1'b0;
    bus.start = 1'b1;
    tick_n(1);
    bus.start = 1'b0;
    ena = 1'b1;
    chk_idle("start ena0", 4);
    tick_n(1);
    chk_idle("start ena0 later", 4);

    // static level with cfg_div=0 holds indefinitely
    do_start(0, 0, 3);
    exp_q = '{3,3,3,3,3,3,3,3,3,3,3,3,3,3,3,3,3,3,3,3};
    run_seq("static", -1);
    chk("static busy", int'(bus.busy), 1);
    do_stop();
    chk_idle("static stop", 3);

    // async reset mid-RUN
    do_start(1, 3, 1);
    tick_n(12);
    chk("prerst code", int'(bus.dac_code), 2);
    chk("prerst busy", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    chk_idle("midrun reset", 0);
    tick_n(2);
    rst_n = 1'b1;
    tick_n(1);
    chk_idle("after reset", 0);

`ifdef DAC_SEQ_BURST_EN
    begin
      int wraps;
      wraps = 0;
      bus.cfg_periods = 8'd2;
      do_start(1, 0, 0);
      bus.cfg_periods = 8'd0;
      for (int i = 1; i <= 26; i++) begin
        tick_n(1);
        if (bus.wrap) wraps++;
        if (i == 24) begin
          chk("burst wrap2", int'(bus.wrap), 1);
          chk("burst busy24", int'(bus.busy), 1);
        end
        if (i == 25) chk_idle("burst end", 0);
      end
      chk("burst wraps", wraps, 2);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dac_code_sequencer.md
Name: dac_code_sequencer

Overview:
- Digital stage directly upstream of the analog DAC/ring-oscillator test macro.
- Generates the 3-bit DAC code and the macro enable from a programmable step-rate waveform engine: static level, up-ramp, down-ramp or triangle.
- The top level muxes its outputs onto the macro's dac0..dac2 and enable pins, in place of direct ui_in drive.
- Runs on the project clock and is gated by ena.

Parameters:
- CODE_W, 3: DAC code width in bits.
- DIV_W, 16: step prescaler width in bits.
- SETTLE_CYC, 8: number of cycles dac_enable is held high with the code at the start value before the first step.

Ports:
- clk  in  1  project clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  design enable; while low, the block behaves as if stop were pulsed every cycle
- start  in  1  single-cycle pulse; begins a sequence
- stop  in  1  single-cycle pulse; aborts the sequence
- cfg_mode  in  2  waveform: 0 static, 1 up-ramp, 2 down-ramp, 3 triangle
- cfg_div  in  DIV_W  step period is cfg_div+1 cycles
- cfg_code  in  CODE_W  level for static mode; start value for ramp and triangle modes
- dac_code  out  CODE_W  code driven to the DAC bit pins
- dac_enable  out  1  enable to the analog macro
- busy  out  1  high in SETTLE and RUN
- wrap  out  1  one-cycle pulse on each waveform period boundary

Behaviour:
- Reset values (asynchronous on rst_n low): state IDLE, dac_code 0, dac_enable 0, busy 0, wrap 0, prescaler 0, direction up.
- Configuration:
  - cfg_mode, cfg_div and cfg_code are sampled only on an accepted start.
  - Changes to them while busy have no effect.
- States and transitions:
  - IDLE: dac_enable 0 and dac_code holds its last value. On start with ena=1: load dac_code=cfg_code, set dac_enable=1, clear the settle counter, go to SETTLE on the next edge.
  - SETTLE: count SETTLE_CYC cycles, then go to RUN with the prescaler cleared.
  - RUN: the prescaler counts 0..cfg_div. When it reaches cfg_div, it returns to 0 and one step is applied:
    - mode 0: no change to the code.
    - mode 1: code+1 modulo 2^CODE_W. wrap pulses on the 7->0 transition.
    - mode 2: code-1 modulo 2^CODE_W. wrap pulses on the 0->7 transition.
    - mode 3: count up to 7, then down to 0, with no repeated endpoint (…6,7,6,…,1,0,1…). wrap pulses on the step that reaches 0. A cfg_code of 7 starts with direction down; any other value starts with direction up.
    - mode 0 with cfg_div=0 is legal: the block holds the level indefinitely.
- Step timing: with cfg_div=0, the code changes every cycle in RUN.
- stop (or ena low) in SETTLE or RUN: go to IDLE on the next edge. dac_enable drops the same edge; dac_code freezes.
- start while busy: ignored.
- start and stop in the same cycle: stop wins. From IDLE this means no start.
- wrap is registered, coincides with the updated dac_code, and never asserts outside RUN.
- All outputs are registered, with no combinational path from inputs to outputs.

Optional Feature:
- Macro DAC_SEQ_BURST_EN.
- When defined:
  - Adds input cfg_periods [7:0], sampled on start.
  - In RUN the block counts wrap pulses. After cfg_periods wraps it returns to IDLE on the following edge, as if stopped.
  - cfg_periods=0 means run continuously.
  - Mode 0 never wraps and therefore always runs continuously.
- When undefined: the port is absent, and RUN ends only on stop or ena low.

Decomposition:
- Shared package dac_seq_pkg holds:
  - the state enum (IDLE, SETTLE, RUN);
  - the mode enum (MODE_STATIC, MODE_UP, MODE_DOWN, MODE_TRI);
  - constants CODE_MAX and the default SETTLE_CYC.
- One natural sub-module, dac_seq_prescaler: a DIV_W-bit down-counter with load and clear that emits a tick pulse.
- The FSM and code arithmetic stay in the top module.

Test Plan:
- Reset mid-RUN (mode 1, cfg_div=3) -> asserting rst_n low immediately gives dac_code=0, dac_enable=0, busy=0, wrap=0.
- Up-ramp: mode 1, cfg_code=6, cfg_div=1, start -> dac_enable rises next edge; SETTLE lasts 8 cycles; codes then run 6,7,0,1 with each value held 2 cycles; a single wrap coincides with code 0.
- Triangle: mode 3, cfg_code=5, cfg_div=0 -> codes 5,6,7,6,5,4,3,2,1,0,1, one per cycle; wrap only on reaching 0.
- Stop and start together in RUN (mode 2, cfg_code=2) -> next edge IDLE, dac_enable=0, dac_code frozen at its last value; a subsequent start alone restarts from 2.
- ena low for 1 cycle during SETTLE -> return to IDLE; start with ena=0 -> ignored, busy stays 0.
- With DAC_SEQ_BURST_EN: mode 1, cfg_code=0, cfg_div=0, cfg_periods=2 -> exactly 2 wrap pulses, then IDLE one edge later, i.e. 16 RUN cycles after SETTLE.
